// File: rtl/affine_interp_sched_11.sv
// 6-tap 1/16-phase affine luma interpolation sequencer with a 2-stage product/sum pipeline.
// Define AFFINE_ROUND_EN to emit (sum+32)>>>6 instead of the raw x64-scale sum.
module affine_interp_sched_11 #(
  parameter int ROW_LEN  = 8,
  parameter int NUM_ROWS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  frac,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [10:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [17:0] m_data,
  output logic        m_last
);

  localparam int CW = $clog2(ROW_LEN + 5);
  localparam int RW = $clog2(NUM_ROWS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [3:0] frac_q, frac_d;

  logic signed [10:0] win_q [6];
  logic signed [17:0] prod_q [6];
  logic signed [17:0] prod_d [6];
  logic signed [7:0]  coef [6];
  logic tok_q, tlast_q, v1_q, l1_q;
  logic m_valid_q, m_last_q;
  logic signed [17:0] m_data_q;

  logic adv, hs, row_end, mirror;
  logic [3:0] fm;
  logic [47:0] crow;
  logic signed [17:0] sum, rsum, out_d;

  // c0 sits in the top byte
  function automatic logic [47:0] coef_row(input logic [3:0] f);
    logic [47:0] r;
    unique case (f)
      4'd0: r = {8'sd0, 8'sd0, 8'sd64, 8'sd0, 8'sd0, 8'sd0};
      4'd1: r = {8'sd1, -8'sd3, 8'sd63, 8'sd4, -8'sd2, 8'sd1};
      4'd2: r = {8'sd1, -8'sd5, 8'sd62, 8'sd8, -8'sd3, 8'sd1};
      4'd3: r = {8'sd2, -8'sd8, 8'sd60, 8'sd13, -8'sd4, 8'sd1};
      4'd4: r = {8'sd3, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1};
      4'd5: r = {8'sd3, -8'sd11, 8'sd52, 8'sd26, -8'sd8, 8'sd2};
      4'd6: r = {8'sd2, -8'sd9, 8'sd47, 8'sd31, -8'sd10, 8'sd3};
      4'd7: r = {8'sd3, -8'sd11, 8'sd45, 8'sd34, -8'sd10, 8'sd3};
      default: r = {8'sd3, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd3};
    endcase
    return r;
  endfunction

  function automatic logic signed [17:0] smul(
    input logic signed [10:0] x,
    input logic signed [7:0]  c
  );
    logic [6:0] mag;
    logic signed [17:0] xe, acc;
    mag = c[7] ? 7'(-c) : c[6:0];
    xe  = {{7{x[10]}}, x};
    acc = '0;
    for (int i = 0; i < 7; i++)
      if (mag[i]) acc = acc + (xe <<< i);
    return c[7] ? -acc : acc;
  endfunction

  assign adv     = !m_valid_q || m_ready;
  assign s_ready = adv && (state_q == S_PRIME || state_q == S_RUN);
  assign hs      = s_valid && s_ready;
  assign row_end = cnt_q == CW'(ROW_LEN + 4);
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  // phases above 8 reuse the mirrored set in reverse tap order
  always_comb begin
    mirror = frac_q > 4'd8;
    fm     = mirror ? 4'(5'd16 - {1'b0, frac_q}) : frac_q;
    crow   = coef_row(fm);
    for (int k = 0; k < 6; k++) begin
      coef[k]   = mirror ? crow[8*k +: 8] : crow[8*(5-k) +: 8];
      prod_d[k] = smul(win_q[k], coef[k]);
    end
    sum = prod_q[0] + prod_q[1] + prod_q[2]
        + prod_q[3] + prod_q[4] + prod_q[5];
    rsum = sum + 18'sd32;
`ifdef AFFINE_ROUND_EN
    out_d = rsum >>> 6;
`else
    out_d = sum;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    frac_d  = frac_q;
    unique case (state_q)
      S_IDLE:
        if (start) begin
          state_d = S_PRIME;
          cnt_d   = '0;
          row_d   = '0;
          frac_d  = frac;
        end
      S_PRIME:
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(4)) state_d = S_RUN;
        end
      S_RUN:
        if (hs) begin
          if (row_end) begin
            cnt_d = '0;
            if (row_q == RW'(NUM_ROWS - 1)) begin
              state_d = S_DRAIN;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_PRIME;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      // leave once the pipeline is guaranteed empty after this edge
      S_DRAIN:
        if (!tok_q && !v1_q && adv) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      frac_q    <= '0;
      tok_q     <= 1'b0;
      tlast_q   <= 1'b0;
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      for (int k = 0; k < 6; k++) begin
        win_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      frac_q  <= frac_d;
      if (hs) begin
        for (int k = 0; k < 5; k++) win_q[k] <= win_q[k+1];
        win_q[5] <= s_data;
      end
      if (adv) begin
        tok_q     <= hs && state_q == S_RUN;
        tlast_q   <= hs && state_q == S_RUN && row_end;
        v1_q      <= tok_q;
        l1_q      <= tlast_q;
        m_valid_q <= v1_q;
        m_last_q  <= l1_q;
        for (int k = 0; k < 6; k++) prod_q[k] <= prod_d[k];
        if (v1_q) m_data_q <= out_d;
      end
    end
  end

endmodule
